// File: rtl/reset_req_if.sv
// Core-bus access port for reset_req: select, write strobe, word address, data, acknowledge.
interface reset_req_if;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output cs, we, address, write_data, input read_data, ready);
  modport slave  (input cs, we, address, write_data, output read_data, ready);
endinterface

// File: rtl/reset_req.sv
// Bus-mapped reset requester: one fixed-length sys_reset pulse per reset epoch.
// Optional kickable watchdog compiled in with `define RESET_REQ_WATCHDOG_EN.
module reset_req #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter logic [31:0] KICK_KEY     = 32'h5a5a_a5a5,
  parameter logic [31:0] SWRST_KEY    = 32'hdead_b007
) (
  input  logic        clk,
  input  logic        reset_n,
  reset_req_if.slave  bus,
  output logic        sys_reset
);

  localparam logic [7:0] A_NAME0   = 8'h00;
  localparam logic [7:0] A_VERSION = 8'h01;
  localparam logic [7:0] A_CTRL    = 8'h08;
  localparam logic [7:0] A_TIMEOUT = 8'h09;
  localparam logic [7:0] A_KICK    = 8'h0a;
  localparam logic [7:0] A_SWRST   = 8'h0b;
  localparam logic [7:0] A_STATUS  = 8'h0c;
  localparam logic [7:0] A_COUNT   = 8'h0d;

  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, DONE = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cause_q, cause_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic        wr, sw_req, bad_kick, wd_expire;
  logic        wd_en;
  logic [31:0] timeout_r, count_r;

  assign wr     = bus.cs & bus.we;
  assign sw_req = wr && (bus.address == A_SWRST) && (bus.write_data == SWRST_KEY);

`ifdef RESET_REQ_WATCHDOG_EN
  logic        wd_en_q, wd_en_d;
  logic [31:0] timeout_q, timeout_d;
  logic [31:0] count_q, count_d;
  logic        kick_wr, kick_ok;

  // Kicks only matter while armed and idle; once a request is in flight they are moot.
  assign kick_wr  = wr && (bus.address == A_KICK) && wd_en_q && (state_q == IDLE);
  assign kick_ok  = kick_wr && (bus.write_data == KICK_KEY);
  assign bad_kick = kick_wr && !kick_ok;

  always_comb begin
    wd_en_d   = wd_en_q;
    timeout_d = timeout_q;
    count_d   = count_q;
    wd_expire = 1'b0;
    if (wr && (bus.address == A_TIMEOUT) && !wd_en_q) timeout_d = bus.write_data;
    if (wr && (bus.address == A_CTRL) && bus.write_data[0] && !wd_en_q) begin
      wd_en_d = 1'b1;
      count_d = timeout_q;
    end else if (wd_en_q && (state_q == IDLE)) begin
      if (kick_ok) begin
        count_d = timeout_q;
      end else begin
        // Request fires on the edge where the count lands on 0, so pulse aligns with expiry.
        count_d   = (count_q == 32'd0) ? 32'd0 : count_q - 32'd1;
        wd_expire = (count_q <= 32'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_en_q   <= 1'b0;
      timeout_q <= 32'h00ff_ffff;
      count_q   <= 32'd0;
    end else begin
      wd_en_q   <= wd_en_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  assign wd_en     = wd_en_q;
  assign timeout_r = timeout_q;
  assign count_r   = count_q;
`else
  assign bad_kick  = 1'b0;
  assign wd_expire = 1'b0;
  assign wd_en     = 1'b0;
  assign timeout_r = 32'd0;
  assign count_r   = 32'd0;
`endif

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      IDLE: begin
        if (sw_req || bad_kick || wd_expire) begin
          state_d = ASSERT;
          pcnt_d  = 8'(PULSE_CYCLES - 1);
          cause_d = sw_req ? 2'd1 : (bad_kick ? 2'd3 : 2'd2);
        end
      end
      ASSERT: begin
        if (pcnt_q == 8'd0) state_d = DONE;
        else                pcnt_d  = pcnt_q - 8'd1;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cause_q <= 2'd0;
      pcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign sys_reset = (state_q == ASSERT);
  assign bus.ready = bus.cs;

  always_comb begin
    bus.read_data = 32'd0;
    if (bus.cs) begin
      case (bus.address)
        A_NAME0:   bus.read_data = 32'h7273_7471;
        A_VERSION: bus.read_data = 32'h0000_0001;
        A_CTRL:    bus.read_data = {31'd0, wd_en};
        A_TIMEOUT: bus.read_data = timeout_r;
        A_STATUS:  bus.read_data = {27'd0, state_q, cause_q, wd_en};
        A_COUNT:   bus.read_data = count_r;
        default:   bus.read_data = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_req.sv
// Scoreboard bench for reset_req: stimulus queues expected reads and pulse lengths,
// negedge monitors pop and compare. Watchdog scenarios run when RESET_REQ_WATCHDOG_EN is defined.
module tb_reset_req;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sys_reset;

  reset_req_if bus();

  reset_req dut (.clk(clk), .reset_n(reset_n), .bus(bus), .sys_reset(sys_reset));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_rd[$];
  int          exp_pulse[$];
  int          plen = 0;

  localparam logic [31:0] KEY_SW   = 32'hdead_b007;
  localparam logic [31:0] KEY_KICK = 32'h5a5a_a5a5;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bus read monitor and pulse-length monitor, both sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.cs) begin
      chk("ready", {31'd0, bus.ready}, 32'd1);
      if (!bus.we) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected@%0h: got %h expected no read", bus.address, bus.read_data);
        end else begin
          chk($sformatf("read@%0h", bus.address), bus.read_data, exp_rd.pop_front());
        end
      end
    end
    if (sys_reset === 1'b1) plen++;
    else if (plen > 0) begin
      if (exp_pulse.size() == 0) begin
        checks++; errors++;
        $display("FAIL pulse_unexpected: got length %0d expected no pulse", plen);
      end else begin
        chk("pulse_len", 32'(plen), 32'(exp_pulse.pop_front()));
      end
      plen = 0;
    end
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.we = 1'b1; bus.address = a; bus.write_data = d;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e);
    exp_rd.push_back(e);
    bus.cs = 1'b1; bus.we = 1'b0; bus.address = a;
    @(posedge clk); #1;
    bus.cs = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("sysrst_async_drop", {31'd0, sys_reset}, 32'd0);
    chk("ready_in_reset", {31'd0, bus.ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    bus.cs = 1'b0; bus.we = 1'b0; bus.address = 8'd0; bus.write_data = 32'd0;
    #1;
    chk("rst_sys_reset", {31'd0, sys_reset}, 32'd0);
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_read_data", bus.read_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Identification and reset state
    rd(8'h00, 32'h7273_7471);
    rd(8'h01, 32'h0000_0001);
    rd(8'h0c, 32'h0);
    rd(8'h05, 32'h0);

    // Wrong software key: nothing happens
    wr(8'h0b, 32'h0);
    idle(2);
    rd(8'h0c, 32'h0);

`ifndef RESET_REQ_WATCHDOG_EN
    // Watchdog registers absent: writes ignored, reads zero, kicks inert
    wr(8'h08, 32'h1);
    wr(8'h09, 32'h5);
    wr(8'h0a, 32'h1);
    idle(3);
    rd(8'h08, 32'h0);
    rd(8'h09, 32'h0);
    rd(8'h0d, 32'h0);
    rd(8'h0c, 32'h0);
`else
    rd(8'h08, 32'h0);
    rd(8'h09, 32'h00ff_ffff);
    rd(8'h0d, 32'h0);
`endif

    // Software reset: 4-cycle pulse, then DONE is terminal
    exp_pulse.push_back(4);
    wr(8'h0b, KEY_SW);
    idle(1);
    rd(8'h0c, 32'h0a);
    idle(5);
    rd(8'h0c, 32'h12);
    wr(8'h0b, KEY_SW);
    idle(6);
    rd(8'h0c, 32'h12);

    // reset_n during cycle 2 of a pulse truncates it asynchronously
    do_reset();
    rd(8'h0c, 32'h0);
    exp_pulse.push_back(2);
    wr(8'h0b, KEY_SW);
    @(negedge clk); @(negedge clk); #1;
    do_reset();
    rd(8'h0c, 32'h0);
    rd(8'h00, 32'h7273_7471);
    exp_pulse.push_back(4);
    wr(8'h0b, KEY_SW);
    idle(6);
    rd(8'h0c, 32'h12);

`ifdef RESET_REQ_WATCHDOG_EN
    // Timeout: pulse begins 10 cycles after the arming write
    do_reset();
    wr(8'h09, 32'd10);
    exp_pulse.push_back(4);
    wr(8'h08, 32'h1);
    rd(8'h0d, 32'd10);
    wr(8'h09, 32'd20);
    rd(8'h09, 32'd10);
    rd(8'h0d, 32'd7);
    idle(5);
    rd(8'h0c, 32'h01);
    rd(8'h0c, 32'h0d);
    idle(5);
    rd(8'h0c, 32'h15);
    rd(8'h0d, 32'h0);
    wr(8'h08, 32'h0);
    rd(8'h08, 32'h1);

    // Regular good kicks hold off the timeout; a bad kick fires at once
    do_reset();
    wr(8'h09, 32'd10);
    wr(8'h08, 32'h1);
    for (int i = 0; i < 12; i++) begin
      idle(7);
      wr(8'h0a, KEY_KICK);
    end
    rd(8'h0c, 32'h01);
    exp_pulse.push_back(4);
    wr(8'h0a, 32'h1);
    rd(8'h0c, 32'h0f);
    idle(6);
    rd(8'h0c, 32'h17);
    wr(8'h0a, 32'h1);
    idle(6);
    rd(8'h0c, 32'h17);

    // Good kick on the edge the count would reach 0: reload wins
    do_reset();
    wr(8'h09, 32'd3);
    exp_pulse.push_back(4);
    wr(8'h08, 32'h1);
    idle(2);
    wr(8'h0a, KEY_KICK);
    rd(8'h0d, 32'd3);
    rd(8'h0c, 32'h01);
    idle(8);
    rd(8'h0c, 32'h15);
`endif

    idle(8);
    chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    chk("pulse_queue_drained", 32'(exp_pulse.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
